// File: rtl/decode_control_pipe_if.sv
// Fetch-to-decode handshake plus the registered ID/EX entry bundle.
// The master side is fetch/hazard logic; the slave side is decode_control_pipe.
interface decode_control_pipe_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CTRL_W  = 8
);
  logic               in_valid;
  logic [INSTR_W-1:0] instr;
  logic               in_ready;
  logic               stall;
  logic               flush;
  logic               out_valid;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [INSTR_W-1:0] out_instr;
  logic [INSTR_W-1:0] out_imm;
  logic               illegal;
  logic               busy;

  modport master (
    output in_valid, instr, stall, flush,
    input  in_ready, out_valid, out_ctrl, out_instr, out_imm, illegal, busy
  );

  modport slave (
    input  in_valid, instr, stall, flush,
    output in_ready, out_valid, out_ctrl, out_instr, out_imm, illegal, busy
  );
endinterface

// File: rtl/decode_control_pipe.sv
// Decode stage with registered ID/EX entry; LDM takes its immediate from
// the following fetched word, holding the LDM instruction until it arrives.
module decode_control_pipe #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned CTRL_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_control_pipe_if.slave bus
);

  typedef enum logic {
    S_DEC = 1'b0,
    S_IMM = 1'b1
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LDM = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(5);

  state_e             state_q,     state_d;
  logic               out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]  out_ctrl_q,  out_ctrl_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [INSTR_W-1:0] out_imm_q,   out_imm_d;
  logic               illegal_q,   illegal_d;
  logic [INSTR_W-1:0] ldm_word_q,  ldm_word_d;

  logic [OPCODE_W-1:0] opcode;
  logic [CTRL_W-1:0]   dec_ctrl;
  logic [CTRL_W-1:0]   ldm_ctrl;
  logic                dec_illegal;
  logic                in_ready;
  logic                accept;

  assign in_ready = !bus.stall && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  assign opcode   = bus.instr[INSTR_W-1 -: OPCODE_W];

  // Control bundle bits: 0 not, 1 add, 2 memRead, 3 memWrite, 4 regWrite, 5 ldm.
  always_comb begin
    ldm_ctrl      = '0;
    ldm_ctrl[5:0] = 6'h30;
  end

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LDM:  dec_ctrl[5:0] = 6'h30;
      OP_STD:  dec_ctrl[5:0] = 6'h08;
      OP_ADD:  dec_ctrl[5:0] = 6'h12;
      OP_NOT:  dec_ctrl[5:0] = 6'h11;
      OP_NOP:  dec_ctrl[5:0] = 6'h00;
      default: dec_illegal   = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_instr_d = out_instr_q;
    out_imm_d   = out_imm_q;
    illegal_d   = illegal_q;
    ldm_word_d  = ldm_word_q;

    if (bus.flush) begin
      state_d     = S_DEC;
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
      out_imm_d   = '0;
      illegal_d   = 1'b0;
      ldm_word_d  = '0;
    end else if (bus.stall) begin
      // Everything holds, including a pending LDM.
    end else if (accept) begin
      if (state_q == S_IMM) begin
        // Opcode bits of the immediate word are deliberately ignored.
        state_d     = S_DEC;
        out_valid_d = 1'b1;
        out_ctrl_d  = ldm_ctrl;
        out_instr_d = ldm_word_q;
        out_imm_d   = bus.instr;
        illegal_d   = 1'b0;
      end else if (opcode == OP_LDM) begin
        state_d     = S_IMM;
        ldm_word_d  = bus.instr;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        out_ctrl_d  = dec_ctrl;
        out_instr_d = bus.instr;
        out_imm_d   = '0;
        illegal_d   = dec_illegal;
      end
    end else begin
      // Bubble; illegal must never be seen without out_valid.
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DEC;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_instr_q <= '0;
      out_imm_q   <= '0;
      illegal_q   <= 1'b0;
      ldm_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_instr_q <= out_instr_d;
      out_imm_q   <= out_imm_d;
      illegal_q   <= illegal_d;
      ldm_word_q  <= ldm_word_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = (state_q == S_IMM);

endmodule
